// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline: opcodes, ALU/writeback selects
// and the decoded control bundle carried from ID to EX.
package pipeline_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_IMM    = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       a_sel;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/pipeline_regfile.sv
// Two-read, one-write register file with x0 tied to zero and a same-cycle
// write-through bypass so ID sees the value WB is retiring this cycle.
module pipeline_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (wr_addr != '0);

  // NOTE: the array is reset because software relies on zeroed registers;
  // this forces flops rather than a RAM macro.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (wr_en && wr_addr == rs1_addr) rs1_data = wr_data;
    if (wr_en && wr_addr == rs2_addr) rs2_data = wr_data;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

endmodule

// File: rtl/pipeline_decode.sv
// ID stage: register read, immediate/control decode, load-use stall and
// branch flush, with a registered ID/EX bundle.
module pipeline_decode
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcsrc_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic            ex_memread_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcsrc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            jalr_o,
  output logic            alu_src_o,
  output logic            a_sel_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      wb_sel_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            use_rs1, use_rs2, issue;
  ctrl_t           ctrl, ctrl_q;

  assign opcode = instruction_i[6:0];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];

  pipeline_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we_i),
    .wr_addr  (wb_rd_i),
    .wr_data  (wb_data_i)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    ctrl    = '0;
    imm     = '0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = (opcode == OPC_LUI) ? ALU_OP_IMM : ALU_OP_ADD;
        ctrl.a_sel     = (opcode == OPC_AUIPC);
        imm            = {instruction_i[31:12], 12'b0};
        use_rs1        = 1'b0;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.wb_sel    = WB_SEL_PC4;
        imm = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
               instruction_i[30:21], 1'b0};
        use_rs1        = 1'b0;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_SEL_PC4;
        imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_BRANCH;
        imm = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
               instruction_i[11:8], 1'b0};
        use_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_SEL_MEM;
        imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
        use_rs2        = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
        imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
        use_rs2        = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // A flush kills the hazard too: the stalled instruction is being discarded.
  assign stall_o = valid_i && ex_memread_i && (ex_rd_i != 5'd0) && !flush_i &&
                   ((use_rs1 && rs1 == ex_rd_i) || (use_rs2 && rs2 == ex_rd_i));
  assign issue   = valid_i && !flush_i && !stall_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o    <= 1'b0;
      ctrl_q     <= '0;
      pc_o       <= '0;
      pcsrc_o    <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
    end else begin
      valid_o    <= issue;
      ctrl_q     <= issue ? ctrl : '0;
      pc_o       <= pc_i;
      pcsrc_o    <= pcsrc_i;
      rs1_data_o <= rs1_data;
      rs2_data_o <= rs2_data;
      imm_o      <= imm;
      rs1_o      <= rs1;
      rs2_o      <= rs2;
      rd_o       <= instruction_i[11:7];
      funct3_o   <= instruction_i[14:12];
      funct7b5_o <= instruction_i[30];
    end
  end

  assign reg_write_o = ctrl_q.reg_write;
  assign mem_read_o  = ctrl_q.mem_read;
  assign mem_write_o = ctrl_q.mem_write;
  assign branch_o    = ctrl_q.branch;
  assign jump_o      = ctrl_q.jump;
  assign jalr_o      = ctrl_q.jalr;
  assign alu_src_o   = ctrl_q.alu_src;
  assign a_sel_o     = ctrl_q.a_sel;
  assign alu_op_o    = ctrl_q.alu_op;
  assign wb_sel_o    = ctrl_q.wb_sel;
  assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_pipeline_decode.sv
// Bench for pipeline_decode: directed plan items plus random traffic,
// with a reference model feeding a scoreboard drained by a monitor.
module tb_pipeline_decode;

  typedef struct packed {
    logic [31:0] pc, pcsrc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic        rw, mr, mw, br, jp, jr, asrc, asel;
    logic [1:0]  aop, wsel;
    logic        ill;
  } obs_t;

  logic        clk_i = 1'b0, reset_i;
  logic [31:0] instruction_i, pc_i, pcsrc_i, wb_data_i;
  logic        valid_i, flush_i, ex_memread_i, wb_we_i;
  logic [4:0]  ex_rd_i, wb_rd_i;
  logic        stall_o, valid_o, funct7b5_o;
  logic [31:0] pc_o, pcsrc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, jalr_o;
  logic        alu_src_o, a_sel_o, illegal_o;
  logic [1:0]  alu_op_o, wb_sel_o;

  pipeline_decode dut (
    .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i), .pc_i(pc_i),
    .pcsrc_i(pcsrc_i), .valid_i(valid_i), .flush_i(flush_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .wb_we_i(wb_we_i),
    .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .pcsrc_o(pcsrc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .jump_o(jump_o), .jalr_o(jalr_o),
    .alu_src_o(alu_src_o), .a_sel_o(a_sel_o), .alu_op_o(alu_op_o), .wb_sel_o(wb_sel_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0, bad = 0;
  obs_t        exp_q[$];
  logic [31:0] ref_rf[32];
  obs_t        act;
  logic [12:0] ctrl_bits;
  logic [31:0] reset_vec_lo;
  logic [191:0] all_regs;

  assign act = {pc_o, pcsrc_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o,
                funct3_o, funct7b5_o, reg_write_o, mem_read_o, mem_write_o, branch_o,
                jump_o, jalr_o, alu_src_o, a_sel_o, alu_op_o, wb_sel_o, illegal_o};
  assign ctrl_bits = {reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, jalr_o,
                      alu_src_o, a_sel_o, alu_op_o, wb_sel_o, illegal_o};
  assign all_regs = {act, valid_o};
  assign reset_vec_lo = 32'd0;

  task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] sx(input int unsigned v, input int bits);
    int s;
    s = int'(v << (32 - bits)) >>> (32 - bits);
    return 32'(s);
  endfunction

  // Reference decode straight from the ISA tables.
  function automatic obs_t model(input logic [31:0] inst, pc, pcsrc, r1d, r2d);
    obs_t e;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    i_imm = sx(inst >> 20, 12);
    s_imm = sx(((inst >> 25) << 5) | ((inst >> 7) & 32'h1f), 12);
    b_imm = sx((inst[31] * 4096) + (inst[7] * 2048) + (((inst >> 25) & 32'h3f) * 32)
               + (((inst >> 8) & 32'hf) * 2), 13);
    u_imm = inst & 32'hFFFF_F000;
    j_imm = sx((inst[31] * (1 << 20)) + (((inst >> 12) & 32'hff) * (1 << 12))
               + (inst[20] * 2048) + (((inst >> 21) & 32'h3ff) * 2), 21);
    e = '0;
    e.pc = pc; e.pcsrc = pcsrc; e.rs1d = r1d; e.rs2d = r2d;
    e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
    e.f3 = inst[14:12]; e.f7 = inst[30];
    case (inst[6:0])
      7'b0110111: begin e.rw = 1; e.aop = 2'b11; e.asrc = 1; e.imm = u_imm; end
      7'b0010111: begin e.rw = 1; e.asel = 1; e.asrc = 1; e.imm = u_imm; end
      7'b1101111: begin e.rw = 1; e.jp = 1; e.wsel = 2'b10; e.imm = j_imm; end
      7'b1100111: begin e.rw = 1; e.jp = 1; e.jr = 1; e.asrc = 1; e.wsel = 2'b10; e.imm = i_imm; end
      7'b1100011: begin e.br = 1; e.aop = 2'b01; e.imm = b_imm; end
      7'b0000011: begin e.rw = 1; e.mr = 1; e.asrc = 1; e.wsel = 2'b01; e.imm = i_imm; end
      7'b0100011: begin e.mw = 1; e.asrc = 1; e.imm = s_imm; end
      7'b0010011: begin e.rw = 1; e.aop = 2'b10; e.asrc = 1; e.imm = i_imm; end
      7'b0110011: begin e.rw = 1; e.aop = 2'b10; end
      7'b0001111, 7'b1110011: e.imm = i_imm;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_we_i && wb_rd_i == r) return wb_data_i;
    return ref_rf[r];
  endfunction

  // One cycle: predict stall, queue the expected issue, advance to next negedge.
  task automatic step(output bit stalled);
    logic [6:0] op;
    bit use1, use2;
    op   = instruction_i[6:0];
    use1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    use2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    stalled = valid_i && ex_memread_i && ex_rd_i != 0 && !flush_i &&
              ((use1 && instruction_i[19:15] == ex_rd_i) || (use2 && instruction_i[24:20] == ex_rd_i));
    #1 check("stall", 256'(stall_o), 256'(stalled));
    if (valid_i && !flush_i && !stalled)
      exp_q.push_back(model(instruction_i, pc_i, pcsrc_i,
                            read_model(instruction_i[19:15]), read_model(instruction_i[24:20])));
    @(posedge clk_i);
    if (wb_we_i && wb_rd_i != 0) ref_rf[wb_rd_i] = wb_data_i;
    @(negedge clk_i);
  endtask

  task automatic set_idle();
    instruction_i = 32'h0000_0013; pc_i = 32'h100; pcsrc_i = 32'h104;
    valid_i = 0; flush_i = 0; ex_memread_i = 0; ex_rd_i = 0;
    wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
  endtask

  task automatic issue(input logic [31:0] inst);
    instruction_i = inst; valid_i = 1;
    pc_i = pc_i + 4; pcsrc_i = pc_i + 4;
  endtask

  // Monitor: pops on every valid output, otherwise bubbles must carry no controls.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (reset_i) continue;
      if (valid_o) begin
        if (exp_q.size() == 0) check("unexpected_valid", 256'(valid_o), 256'(0));
        else begin
          e = exp_q.pop_front();
          check("txn", 256'(act), 256'(e));
        end
      end else begin
        check("bubble_ctrl", 256'(ctrl_bits), 256'(0));
      end
    end
  end

  initial begin
    bit st;
    logic [6:0] ops[11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                            7'b1110011};
    for (int i = 0; i < 32; i++) ref_rf[i] = 0;
    set_idle();
    reset_i = 1;
    #3 check("reset_state", 256'(all_regs), 256'(reset_vec_lo));
    @(negedge clk_i); @(negedge clk_i);
    reset_i = 0;

    // Write x1 while issuing add x2,x1,x1, then reset asynchronously.
    wb_we_i = 1; wb_rd_i = 1; wb_data_i = 32'h1234;
    issue(32'h0010_8133);
    step(st);
    check("bypass_pre_reset", 256'(rs1_data_o), 256'(32'h1234));
    set_idle();
    #2 reset_i = 1;
    #1 check("async_reset", 256'(all_regs), 256'(reset_vec_lo));
    for (int i = 0; i < 32; i++) ref_rf[i] = 0;
    exp_q.delete();
    @(negedge clk_i);
    reset_i = 0;
    issue(32'h0010_8133);
    step(st);
    check("x1_after_reset", 256'(rs1_data_o), 256'(0));

    // addi x1,x0,5
    set_idle(); issue(32'h0050_0093); step(st);
    check("addi_valid", 256'(valid_o), 256'(1));
    check("addi_fields", 256'({rd_o, imm_o, reg_write_o, alu_src_o, alu_op_o, wb_sel_o}),
          256'({5'd1, 32'd5, 1'b1, 1'b1, 2'b10, 2'b00}));

    // add x3,x2,x2 with x2 retiring this cycle
    set_idle(); wb_we_i = 1; wb_rd_i = 2; wb_data_i = 32'hDEAD_BEEF;
    issue(32'h0021_01B3); step(st);
    check("wt_bypass", 256'({rs1_data_o, rs2_data_o}), 256'({32'hDEAD_BEEF, 32'hDEAD_BEEF}));

    // Load-use on x5, then release
    set_idle(); ex_memread_i = 1; ex_rd_i = 5; issue(32'h0002_8333);
    #1 check("lu_stall", 256'(stall_o), 256'(1));
    step(st);
    check("lu_bubble", 256'(valid_o), 256'(0));
    ex_memread_i = 0; step(st);
    check("lu_release", 256'({valid_o, rd_o}), 256'({1'b1, 5'd6}));

    // Hazard together with flush
    ex_memread_i = 1; ex_rd_i = 5; flush_i = 1;
    #1 check("flush_kills_stall", 256'(stall_o), 256'(0));
    step(st);
    check("flush_bubble", 256'(valid_o), 256'(0));

    // beq x0,x0,-4 and jal x1,2048
    set_idle(); issue(32'hFE00_0EE3); step(st);
    check("beq", 256'({imm_o, branch_o, reg_write_o}), 256'({32'hFFFF_FFFC, 1'b1, 1'b0}));
    issue(32'h0010_00EF); step(st);
    check("jal", 256'({imm_o, jump_o, wb_sel_o}), 256'({32'h0000_0800, 1'b1, 2'b10}));

    // Random traffic; a stalled instruction is held and re-presented by fetch.
    set_idle();
    st = 0;
    for (int n = 0; n < 600; n++) begin
      if (!st) begin
        logic [31:0] inst;
        int k;
        inst = $urandom;
        k = $urandom_range(0, 11);
        inst[6:0] = (k == 11) ? 7'($urandom) : ops[k];
        inst[19:15] = 5'($urandom_range(0, 7));
        inst[24:20] = 5'($urandom_range(0, 7));
        instruction_i = inst;
        valid_i = ($urandom_range(0, 9) != 0);
        pc_i = $urandom; pcsrc_i = pc_i + 4;
      end
      flush_i = ($urandom_range(0, 9) == 0);
      ex_memread_i = ($urandom_range(0, 2) == 0);
      ex_rd_i = 5'($urandom_range(0, 7));
      wb_we_i = $urandom_range(0, 1);
      wb_rd_i = 5'($urandom_range(0, 7));
      wb_data_i = $urandom;
      step(st);
      if (flush_i) st = 0;
    end

    set_idle();
    repeat (3) @(negedge clk_i);
    check("drain", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
